lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
Sequential load/store unit for the memory stage, connecting the pipeline to the data bus.
- Accepts one memory op per handshake and computes the effective address.
- Raises AdEL/AdES on misalignment.
- Drives a two-phase bus request (addr_ok, then data_ok) held stable until accepted.
- Returns a registered, extended load result.
- Adds LWL/LWR/SWL/SWR, a parametrised bus width, and flush-safe draining of in-flight accesses.

Parameters:
ADDR_W, 32, address width.
DATA_W, 32, bus data width; legal values 32 or 64. Byte lanes NB = DATA_W/8; lane index bits LB = log2(NB).

Ports:
clk  in  1  clock
resetn  in  1  reset; asynchronous, active-low
req_valid  in  1  pipeline presents an op
req_ready  out  1  high only in IDLE
req_op  in  4  lsu_op_e: LB,LBU,LH,LHU,LW,LWL,LWR,SB,SH,SW,SWL,SWR
req_base, req_offset  in  ADDR_W each  address operands (sum, wrap mod 2^ADDR_W)
req_wdata  in  32  store data (rt)
req_old  in  32  old rt value, merged by LWL/LWR
flush  in  1  cp0 flush; kills accept and in-flight result
dreq_valid  out  1  bus request valid
dreq_addr  out  ADDR_W  bus address
dreq_size  out  3  msize: 0 = byte, 1 = half, 2 = word
dreq_strobe  out  NB  byte-write enables; zero for loads
dreq_data  out  DATA_W  lane-positioned store data
dresp_addr_ok  in  1  address phase accepted
dresp_data_ok  in  1  data phase complete
dresp_data  in  DATA_W  read data
resp_valid  out  1  one-cycle completion pulse
resp_data  out  32  load result; 0 for stores and exceptions
exc_adel, exc_ades  out  1  misaligned load / misaligned store; valid with resp_valid
badvaddr  out  ADDR_W  faulting effective address, else 0

Behaviour:
Reset: all outputs 0, FSM in IDLE.

FSM states: IDLE, ADDR, DATA, DRAIN.

Accept: a request is accepted when IDLE & req_valid & ~flush. On accept:
- ea = base + offset; register the op, ea, data and old.
- Alignment: LH/LHU/SH need ea[0]=0; LW/SW need ea[1:0]=0. Byte ops and LWL/LWR/SWL/SWR are never misaligned.

Misaligned op:
- No bus activity; stay in IDLE.
- Next cycle: resp_valid=1, exc_adel or exc_ades =1, badvaddr=ea.

Aligned op:
- Next cycle: ADDR, with dreq_valid=1.
- dreq_addr=ea for normal ops; {ea[ADDR_W-1:2],2'b00} for LWL/LWR/SWL/SWR.
- dreq_size = 2 for LWL/LWR/SWL/SWR.

ADDR state:
- All dreq_* held constant until dresp_addr_ok; a request is never withdrawn.
- addr_ok & data_ok in the same cycle: complete.
- addr_ok only: go to DATA, dreq_valid=0.

DATA state: data_ok completes the access.

Completion:
- Next cycle resp_valid=1 and resp_data=result; return to IDLE.
- Minimum latency from accept to resp_valid: 2 cycles.

Flush while busy:
- ADDR: keep requesting until addr_ok, mark discard. If data_ok arrives in the same cycle, go to IDLE with no resp; otherwise go to DRAIN.
- DATA: go to DRAIN.
- DRAIN: on data_ok go to IDLE; resp_valid stays 0.
- Stores already issued still complete in memory.

Flush in IDLE: no accept. A registered misaligned exception pending for that cycle is suppressed.

Lanes: l = ea[LB-1:0].
- SB: strobe bit l set; data byte placed at lane l.
- SH: strobes l, l+1; halfword placed at lanes l..l+1.
- SW: strobes l..l+3; word placed at lanes l..l+3.
- For DATA_W=64, the word sits in lane group ea[2].

Loads: extract the byte/half/word from the lane group, then zero-extend (LBU/LHU) or sign-extend (LB/LH).

Unaligned words: a=ea[1:0]; w = 32-bit lane word.
- LWL: (w << 8(3-a)) | (old & ((1 << 8(3-a)) - 1)).
- LWR: (w >> 8a) | (old & ~(32'hFFFFFFFF >> 8a)).
- SWL: strobe low a+1 bytes; data = rt >> 8(3-a).
- SWR: strobe bytes a..3; data = rt << 8a.
- Strobe and data shift within the word group for DATA_W=64.

Simultaneous events: req_valid is ignored outside IDLE. A data_ok pulse in IDLE is ignored.

Reset mid-operation: return to IDLE at once with all outputs 0. The bus side is assumed reset together with the unit.

Decomposition:
Shared package (cpu_pkg):
- lsu_op_e enum.
- msize_t constants MSIZE1/2/4.
- Alignment and extend helpers.

Sub-module lsu_lane: combinational strobe/data positioning and load extraction/merge, parametrised by DATA_W. The FSM, registers and flush logic stay in lsu_ctrl.

Test Plan:
1. SB, base=0x1000, offset=3, wdata=0xAB, DATA_W=32 -> dreq_addr=0x1003, strobe=1000, data=0xAB000000; resp_valid 2 cycles after accept when addr_ok & data_ok are given together.
2. LH at ea=0x2002, dresp_data=0x8001_1234 -> resp_data=0xFFFF8001; LHU -> 0x00008001; LH at ea=0x2001 -> exc_adel=1, badvaddr=0x2001, dreq_valid never asserted.
3. LWL at ea=0x11, mem=0x44332211, old=0xAABBCCDD -> dreq_addr=0x10, resp_data=0x2211CCDD; LWR same ea -> 0xAA443322.
4. SWL at ea=0x11, rt=0x11223344 -> strobe=0011, data=0x00001122; SWR at ea=0x11, same rt -> strobe=1110, data=0x22334400.
5. LW issued, addr_ok stalled 3 cycles -> dreq fields stable throughout; flush during DATA -> DRAIN, no resp_valid, next request accepted the cycle after data_ok.
6. DATA_W=64: SW at ea=0x104, wdata=0xDEADBEEF -> strobe=0xF0, data=0xDEADBEEF_00000000; resetn deasserted mid-ADDR -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the load/store unit: op encoding, bus
// transfer sizes, and the alignment / extension helpers.
package cpu_pkg;

    typedef enum logic [3:0] {
        LSU_LB,
        LSU_LBU,
        LSU_LH,
        LSU_LHU,
        LSU_LW,
        LSU_LWL,
        LSU_LWR,
        LSU_SB,
        LSU_SH,
        LSU_SW,
        LSU_SWL,
        LSU_SWR
    } lsu_op_e;

    typedef logic [2:0] msize_t;

    localparam msize_t MSIZE1 = 3'd0;
    localparam msize_t MSIZE2 = 3'd1;
    localparam msize_t MSIZE4 = 3'd2;

    function automatic logic is_store(input lsu_op_e op);
        return op inside {LSU_SB, LSU_SH, LSU_SW, LSU_SWL, LSU_SWR};
    endfunction

    // LWL/LWR/SWL/SWR always access the whole aligned word.
    function automatic logic is_partial_word(input lsu_op_e op);
        return op inside {LSU_LWL, LSU_LWR, LSU_SWL, LSU_SWR};
    endfunction

    function automatic msize_t op_size(input lsu_op_e op);
        case (op)
            LSU_LB, LSU_LBU, LSU_SB: return MSIZE1;
            LSU_LH, LSU_LHU, LSU_SH: return MSIZE2;
            default:                 return MSIZE4;
        endcase
    endfunction

    function automatic logic is_misaligned(input lsu_op_e op, input logic [1:0] a);
        case (op)
            LSU_LH, LSU_LHU, LSU_SH: return a[0];
            LSU_LW, LSU_SW:          return |a;
            default:                 return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] extend8(input logic [7:0] b, input logic sgn);
        return {{24{sgn & b[7]}}, b};
    endfunction

    function automatic logic [31:0] extend16(input logic [15:0] h, input logic sgn);
        return {{16{sgn & h[15]}}, h};
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering for the load/store unit: positions store strobes and
// data on the bus, and extracts/extends/merges load data from the bus.
module lsu_lane
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  lsu_op_e                 op,
    input  logic [$clog2(DATA_W/8)-1:0] lane,
    input  logic [31:0]             wdata,
    input  logic [31:0]             old,
    input  logic [DATA_W-1:0]       rdata,
    output logic [DATA_W/8-1:0]     strobe,
    output logic [DATA_W-1:0]       wr_data,
    output logic [31:0]             ld_data
);

    localparam int NB = DATA_W / 8;
    localparam int LB = $clog2(NB);

    logic [1:0]    a;
    logic [LB-1:0] grp;
    logic [4:0]    sh_a;
    logic [4:0]    sh_na;
    logic [3:0]    s4;
    logic [31:0]   d32;
    logic [31:0]   w;
    logic [31:0]   w_sh;

    assign a     = lane[1:0];
    assign grp   = lane >> 2;          // which 32-bit word group on a wide bus
    assign sh_a  = {a, 3'b000};        // 8*a
    assign sh_na = {~a, 3'b000};       // 8*(3-a)

    // Store strobes and data within one 32-bit word group.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        s4  = 4'b0000;
        d32 = 32'h0;
        case (op)
            LSU_SB: begin
                s4  = 4'b0001 << a;
                d32 = {24'h0, wdata[7:0]} << sh_a;
            end
            LSU_SH: begin
                s4  = 4'b0011 << a;
                d32 = {16'h0, wdata[15:0]} << sh_a;
            end
            LSU_SW: begin
                s4  = 4'b1111;
                d32 = wdata;
            end
            LSU_SWL: begin
                s4  = 4'b1111 >> ~a;
                d32 = wdata >> sh_na;
            end
            LSU_SWR: begin
                s4  = 4'b1111 << a;
                d32 = wdata << sh_a;
            end
            default: ;
        endcase
    end

    assign strobe  = NB'(s4) << {grp, 2'b00};
    assign wr_data = DATA_W'(d32) << {grp, 5'b00000};

    assign w    = 32'(rdata >> {grp, 5'b00000});
    assign w_sh = w >> sh_a;

    // Load extraction, extension and LWL/LWR merge with the old rt value.
    always_comb begin
        ld_data = 32'h0;
        case (op)
            LSU_LB:  ld_data = extend8(w_sh[7:0], 1'b1);
            LSU_LBU: ld_data = extend8(w_sh[7:0], 1'b0);
            LSU_LH:  ld_data = extend16(w_sh[15:0], 1'b1);
            LSU_LHU: ld_data = extend16(w_sh[15:0], 1'b0);
            LSU_LW:  ld_data = w;
            LSU_LWL: ld_data = (w << sh_na) | (old & ~(32'hFFFF_FFFF << sh_na));
            LSU_LWR: ld_data = (w >> sh_a) | (old & ~(32'hFFFF_FFFF >> sh_a));
            default: ld_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Memory-stage load/store unit: accepts one op per handshake, checks
// alignment, runs the two-phase bus access and returns a registered result.
// A flush while busy lets the bus transaction finish but drops its result.
module lsu_ctrl
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [3:0]            req_op,
    input  logic [ADDR_W-1:0]     req_base,
    input  logic [ADDR_W-1:0]     req_offset,
    input  logic [31:0]           req_wdata,
    input  logic [31:0]           req_old,
    input  logic                  flush,
    output logic                  dreq_valid,
    output logic [ADDR_W-1:0]     dreq_addr,
    output logic [2:0]            dreq_size,
    output logic [DATA_W/8-1:0]   dreq_strobe,
    output logic [DATA_W-1:0]     dreq_data,
    input  logic                  dresp_addr_ok,
    input  logic                  dresp_data_ok,
    input  logic [DATA_W-1:0]     dresp_data,
    output logic                  resp_valid,
    output logic [31:0]           resp_data,
    output logic                  exc_adel,
    output logic                  exc_ades,
    output logic [ADDR_W-1:0]     badvaddr
);

    localparam int NB = DATA_W / 8;
    localparam int LB = $clog2(NB);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_DRAIN
    } state_e;

    state_e            state_q, state_d;
    lsu_op_e           op_in, op_q;
    logic [ADDR_W-1:0] ea, ea_q;
    logic [31:0]       wdata_q, old_q;
    logic              discard_q;
    logic              accept, acc_mis, kill, complete, in_addr;

    logic              resp_valid_q, exc_adel_q, exc_ades_q, exc_sup;
    logic [31:0]       resp_data_q;
    logic [ADDR_W-1:0] badvaddr_q;

    logic [NB-1:0]     lane_strobe;
    logic [DATA_W-1:0] lane_wdata;
    logic [31:0]       lane_ld;

    assign op_in   = lsu_op_e'(req_op);
    assign ea      = req_base + req_offset;
    assign accept  = (state_q == S_IDLE) && req_valid && !flush;
    assign acc_mis = accept && is_misaligned(op_in, ea[1:0]);
    assign kill    = discard_q || flush;
    assign in_addr = (state_q == S_ADDR);

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: registers use non-blocking <= so every flop samples pre-edge values.
            state_q <= state_d;
        end
    end

    // Next state and completion detect; a flushed access still runs to data_ok.
    always_comb begin
        state_d  = state_q;
        complete = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept && !acc_mis) state_d = S_ADDR;
            end
            S_ADDR: begin
                if (dresp_addr_ok) begin
                    if (dresp_data_ok) begin
                        state_d  = S_IDLE;
                        complete = !kill;
                    end else begin
                        state_d = kill ? S_DRAIN : S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (dresp_data_ok) begin
                    state_d  = S_IDLE;
                    complete = !flush;
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (dresp_data_ok) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Capture the op on accept; remember a flush seen while still requesting.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q      <= LSU_LB;
            ea_q      <= '0;
            wdata_q   <= 32'h0;
            old_q     <= 32'h0;
            discard_q <= 1'b0;
        end else begin
            if (accept) begin
                op_q      <= op_in;
                ea_q      <= ea;
                wdata_q   <= req_wdata;
                old_q     <= req_old;
                discard_q <= 1'b0;
            end else if (in_addr && flush) begin
                discard_q <= 1'b1;
            end
        end
    end

    // Registered response: completion result or alignment exception.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'h0;
            exc_adel_q   <= 1'b0;
            exc_ades_q   <= 1'b0;
            badvaddr_q   <= '0;
        end else begin
            resp_valid_q <= complete || acc_mis;
            resp_data_q  <= (complete && !is_store(op_q)) ? lane_ld : 32'h0;
            exc_adel_q   <= acc_mis && !is_store(op_in);
            exc_ades_q   <= acc_mis && is_store(op_in);
            badvaddr_q   <= acc_mis ? ea : '0;
        end
    end

    lsu_lane #(
        .DATA_W (DATA_W)
    ) u_lane (
        .op      (op_q),
        .lane    (ea_q[LB-1:0]),
        .wdata   (wdata_q),
        .old     (old_q),
        .rdata   (dresp_data),
        .strobe  (lane_strobe),
        .wr_data (lane_wdata),
        .ld_data (lane_ld)
    );

    // A flush in the cycle an exception is presented cancels that exception.
    assign exc_sup    = flush && (exc_adel_q || exc_ades_q);
    assign resp_valid = resp_valid_q && !exc_sup;
    assign resp_data  = resp_data_q;
    assign exc_adel   = exc_adel_q && !flush;
    assign exc_ades   = exc_ades_q && !flush;
    assign badvaddr   = exc_sup ? '0 : badvaddr_q;

    assign req_ready   = resetn && (state_q == S_IDLE);
    assign dreq_valid  = in_addr;
    assign dreq_addr   = !in_addr ? '0 :
                         is_partial_word(op_q) ? {ea_q[ADDR_W-1:2], 2'b00} : ea_q;
    assign dreq_size   = in_addr ? op_size(op_q) : MSIZE1;
    assign dreq_strobe = in_addr ? lane_strobe : '0;
    assign dreq_data   = (in_addr && is_store(op_q)) ? lane_wdata : '0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: a 32-bit and a 64-bit instance, expected
// responses queued at issue time and checked by per-instance monitors.
module tb_lsu_ctrl;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    // Shared request operands
    logic [3:0]  req_op;
    logic [31:0] req_base, req_offset, req_wdata, req_old;
    logic        flush;

    // 32-bit instance
    logic        req_valid, req_ready, dreq_valid;
    logic [31:0] dreq_addr, dreq_data;
    logic [2:0]  dreq_size;
    logic [3:0]  dreq_strobe;
    logic        addr_ok, data_ok;
    logic [31:0] rdata;
    logic        resp_valid, exc_adel, exc_ades;
    logic [31:0] resp_data, badvaddr;

    // 64-bit instance
    logic        req_valid_w, req_ready_w, dreq_valid_w;
    logic [31:0] dreq_addr_w;
    logic [63:0] dreq_data_w;
    logic [2:0]  dreq_size_w;
    logic [7:0]  dreq_strobe_w;
    logic        addr_ok_w, data_ok_w;
    logic [63:0] rdata_w;
    logic        resp_valid_w, exc_adel_w, exc_ades_w;
    logic [31:0] resp_data_w, badvaddr_w;

    lsu_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_base(req_base), .req_offset(req_offset), .req_wdata(req_wdata),
        .req_old(req_old), .flush(flush),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(addr_ok), .dresp_data_ok(data_ok), .dresp_data(rdata),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .exc_adel(exc_adel), .exc_ades(exc_ades), .badvaddr(badvaddr)
    );

    lsu_ctrl #(.ADDR_W(32), .DATA_W(64)) dut_w (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid_w), .req_ready(req_ready_w), .req_op(req_op),
        .req_base(req_base), .req_offset(req_offset), .req_wdata(req_wdata),
        .req_old(req_old), .flush(flush),
        .dreq_valid(dreq_valid_w), .dreq_addr(dreq_addr_w), .dreq_size(dreq_size_w),
        .dreq_strobe(dreq_strobe_w), .dreq_data(dreq_data_w),
        .dresp_addr_ok(addr_ok_w), .dresp_data_ok(data_ok_w), .dresp_data(rdata_w),
        .resp_valid(resp_valid_w), .resp_data(resp_data_w),
        .exc_adel(exc_adel_w), .exc_ades(exc_ades_w), .badvaddr(badvaddr_w)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        adel;
        logic        ades;
        logic [31:0] bad;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic exp_t mk(input logic [31:0] d, input logic adel,
                                input logic ades, input logic [31:0] bad);
        exp_t e;
        e.data = d; e.adel = adel; e.ades = ades; e.bad = bad;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Response monitors: every resp_valid must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (resetn && resp_valid) begin
            if (q32.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL resp32_unexpected: got resp_valid=1 data=%h, expected no response", resp_data);
            end else begin
                e = q32.pop_front();
                check("resp32_data", resp_data, e.data);
                check("resp32_adel", exc_adel, e.adel);
                check("resp32_ades", exc_ades, e.ades);
                check("resp32_badvaddr", badvaddr, e.bad);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (resetn && resp_valid_w) begin
            if (q64.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL resp64_unexpected: got resp_valid=1 data=%h, expected no response", resp_data_w);
            end else begin
                e = q64.pop_front();
                check("resp64_data", resp_data_w, e.data);
                check("resp64_adel", exc_adel_w, e.adel);
                check("resp64_ades", exc_ades_w, e.ades);
                check("resp64_badvaddr", badvaddr_w, e.bad);
            end
        end
    end

    // Present one op to the 32-bit instance for a single cycle.
    task automatic issue(input lsu_op_e op, input logic [31:0] base, input logic [31:0] off,
                         input logic [31:0] wd, input logic [31:0] old);
        req_op = op; req_base = base; req_offset = off; req_wdata = wd; req_old = old;
        req_valid = 1'b1;
        check("req_ready_at_issue", req_ready, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic issue_w(input lsu_op_e op, input logic [31:0] base, input logic [31:0] off,
                           input logic [31:0] wd);
        req_op = op; req_base = base; req_offset = off; req_wdata = wd; req_old = 32'h0;
        req_valid_w = 1'b1;
        check("req_ready_w_at_issue", req_ready_w, 1'b1);
        @(posedge clk); #1;
        req_valid_w = 1'b0;
    endtask

    // Address phase on the 32-bit bus: checks the request every stalled cycle,
    // then gives addr_ok (with data_ok too when both=1).
    task automatic bus_addr(input string nm, input int stall, input bit both,
                            input logic [31:0] rd, input logic [31:0] e_addr,
                            input logic [2:0] e_size, input logic [3:0] e_strb,
                            input logic [31:0] e_data);
        for (int i = 0; i <= stall; i++) begin
            check($sformatf("%s_dreq_valid", nm), dreq_valid, 1'b1);
            check($sformatf("%s_dreq_addr", nm), dreq_addr, e_addr);
            check($sformatf("%s_dreq_size", nm), dreq_size, e_size);
            check($sformatf("%s_dreq_strobe", nm), dreq_strobe, e_strb);
            if (e_strb != 4'b0000)
                check($sformatf("%s_dreq_data", nm), dreq_data, e_data);
            if (i == stall) begin
                addr_ok = 1'b1;
                data_ok = both;
                rdata   = rd;
            end
            @(posedge clk); #1;
            addr_ok = 1'b0;
            data_ok = 1'b0;
        end
    endtask

    task automatic data_phase(input string nm, input logic [31:0] rd);
        check($sformatf("%s_dreq_valid_in_data", nm), dreq_valid, 1'b0);
        data_ok = 1'b1;
        rdata   = rd;
        @(posedge clk); #1;
        data_ok = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        req_valid = 1'b0; req_valid_w = 1'b0; flush = 1'b0;
        req_op = 4'd0; req_base = 32'h0; req_offset = 32'h0; req_wdata = 32'h0; req_old = 32'h0;
        addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'h0;
        addr_ok_w = 1'b0; data_ok_w = 1'b0; rdata_w = 64'h0;

        // Reset state
        #12;
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_dreq_valid", dreq_valid, 1'b0);
        check("rst_dreq_addr", dreq_addr, 32'h0);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_badvaddr", badvaddr, 32'h0);
        check("rst_w_dreq_strobe", dreq_strobe_w, 8'h00);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        check("post_rst_req_ready", req_ready, 1'b1);

        // SB at 0x1003, both phases at once: resp two cycles after accept
        q32.push_back(mk(32'h0, 1'b0, 1'b0, 32'h0));
        issue(LSU_SB, 32'h1000, 32'h3, 32'h0000_00AB, 32'h0);
        bus_addr("sb", 0, 1'b1, 32'h0, 32'h1003, MSIZE1, 4'b1000, 32'hAB00_0000);
        check("sb_latency_resp_valid", resp_valid, 1'b1);

        // LH sign-extended, LHU zero-extended via split phases, then misaligned LH
        q32.push_back(mk(32'hFFFF_8001, 1'b0, 1'b0, 32'h0));
        issue(LSU_LH, 32'h2000, 32'h2, 32'h0, 32'h0);
        bus_addr("lh", 0, 1'b1, 32'h8001_1234, 32'h2002, MSIZE2, 4'b0000, 32'h0);
        q32.push_back(mk(32'h0000_8001, 1'b0, 1'b0, 32'h0));
        issue(LSU_LHU, 32'h2000, 32'h2, 32'h0, 32'h0);
        bus_addr("lhu", 1, 1'b0, 32'h0, 32'h2002, MSIZE2, 4'b0000, 32'h0);
        data_phase("lhu", 32'h8001_1234);
        q32.push_back(mk(32'h0, 1'b1, 1'b0, 32'h2001));
        issue(LSU_LH, 32'h2000, 32'h1, 32'h0, 32'h0);
        check("lh_mis_no_dreq", dreq_valid, 1'b0);
        @(posedge clk); #1;
        check("lh_mis_no_dreq_later", dreq_valid, 1'b0);

        // LWL / LWR merge
        q32.push_back(mk(32'h2211_CCDD, 1'b0, 1'b0, 32'h0));
        issue(LSU_LWL, 32'h10, 32'h1, 32'h0, 32'hAABB_CCDD);
        bus_addr("lwl", 0, 1'b1, 32'h4433_2211, 32'h10, MSIZE4, 4'b0000, 32'h0);
        q32.push_back(mk(32'hAA44_3322, 1'b0, 1'b0, 32'h0));
        issue(LSU_LWR, 32'h10, 32'h1, 32'h0, 32'hAABB_CCDD);
        bus_addr("lwr", 0, 1'b1, 32'h4433_2211, 32'h10, MSIZE4, 4'b0000, 32'h0);

        // SWL / SWR strobes and data
        q32.push_back(mk(32'h0, 1'b0, 1'b0, 32'h0));
        issue(LSU_SWL, 32'h10, 32'h1, 32'h1122_3344, 32'h0);
        bus_addr("swl", 0, 1'b1, 32'h0, 32'h10, MSIZE4, 4'b0011, 32'h0000_1122);
        q32.push_back(mk(32'h0, 1'b0, 1'b0, 32'h0));
        issue(LSU_SWR, 32'h10, 32'h1, 32'h1122_3344, 32'h0);
        bus_addr("swr", 0, 1'b1, 32'h0, 32'h10, MSIZE4, 4'b1110, 32'h2233_4400);

        // LW (address wraps) stalled 3 cycles, flushed in DATA, drained
        issue(LSU_LW, 32'hFFFF_F000, 32'h0000_4000, 32'h0, 32'h0);
        bus_addr("lw_stall", 3, 1'b0, 32'h0, 32'h3000, MSIZE4, 4'b0000, 32'h0);
        check("lw_data_no_dreq", dreq_valid, 1'b0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("drain_req_ready", req_ready, 1'b0);
        req_op = LSU_SB; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("drain_ignores_req", dreq_valid, 1'b0);
        data_ok = 1'b1; rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        data_ok = 1'b0;
        check("after_drain_req_ready", req_ready, 1'b1);
        q32.push_back(mk(32'hFFFF_FF80, 1'b0, 1'b0, 32'h0));
        issue(LSU_LB, 32'h40, 32'h3, 32'h0, 32'h0);
        bus_addr("lb", 0, 1'b1, 32'h8000_0000, 32'h43, MSIZE1, 4'b0000, 32'h0);

        // Stray data_ok in IDLE must produce nothing
        data_ok = 1'b1;
        @(posedge clk); #1;
        data_ok = 1'b0;
        check("idle_data_ok_ignored", dreq_valid, 1'b0);

        // Flush while still requesting: request held, result discarded
        issue(LSU_SW, 32'h50, 32'h0, 32'h1234_5678, 32'h0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("addr_flush_still_requesting", dreq_valid, 1'b1);
        bus_addr("sw_flushed", 0, 1'b1, 32'h0, 32'h50, MSIZE4, 4'b1111, 32'h1234_5678);
        check("addr_flush_back_idle", req_ready, 1'b1);

        // Misaligned SW exception cancelled by flush; flush also blocks accept
        issue(LSU_SW, 32'h2000, 32'h2, 32'h0, 32'h0);
        flush = 1'b1;
        #1;
        check("flushed_exc_ades", exc_ades, 1'b0);
        @(posedge clk); #1;
        req_op = LSU_LW; req_base = 32'h60; req_offset = 32'h0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0;
        check("flush_blocks_accept", dreq_valid, 1'b0);

        // 64-bit bus: word in upper group, then halfword load from upper group
        q64.push_back(mk(32'h0, 1'b0, 1'b0, 32'h0));
        issue_w(LSU_SW, 32'h100, 32'h4, 32'hDEAD_BEEF);
        check("w_sw_dreq_valid", dreq_valid_w, 1'b1);
        check("w_sw_dreq_addr", dreq_addr_w, 32'h104);
        check("w_sw_dreq_size", dreq_size_w, MSIZE4);
        check("w_sw_dreq_strobe", dreq_strobe_w, 8'hF0);
        check("w_sw_dreq_data", dreq_data_w, 64'hDEAD_BEEF_0000_0000);
        addr_ok_w = 1'b1; data_ok_w = 1'b1;
        @(posedge clk); #1;
        addr_ok_w = 1'b0; data_ok_w = 1'b0;
        q64.push_back(mk(32'hFFFF_8001, 1'b0, 1'b0, 32'h0));
        issue_w(LSU_LH, 32'h100, 32'h6, 32'h0);
        check("w_lh_dreq_addr", dreq_addr_w, 32'h106);
        check("w_lh_dreq_size", dreq_size_w, MSIZE2);
        check("w_lh_dreq_strobe", dreq_strobe_w, 8'h00);
        addr_ok_w = 1'b1; data_ok_w = 1'b1; rdata_w = 64'h8001_0000_0000_0000;
        @(posedge clk); #1;
        addr_ok_w = 1'b0; data_ok_w = 1'b0;

        // Reset asserted mid-ADDR clears outputs without waiting for a clock
        issue_w(LSU_SW, 32'h100, 32'h0, 32'h1234_5678);
        check("w_pre_rst_dreq_valid", dreq_valid_w, 1'b1);
        #2;
        resetn = 1'b0;
        #1;
        check("w_async_rst_dreq_valid", dreq_valid_w, 1'b0);
        check("w_async_rst_dreq_addr", dreq_addr_w, 32'h0);
        check("w_async_rst_dreq_strobe", dreq_strobe_w, 8'h00);
        check("w_async_rst_dreq_data", dreq_data_w, 64'h0);
        check("w_async_rst_req_ready", req_ready_w, 1'b0);
        check("w_async_rst_resp_valid", resp_valid_w, 1'b0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        check("w_post_rst_idle", req_ready_w, 1'b1);
        check("w_post_rst_no_dreq", dreq_valid_w, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("q32_drained", q32.size(), 0);
        check("q64_drained", q64.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
